// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU sharing arbiter and the ALU it feeds:
//   - ALU function codes (codes 0xE/0xF are unassigned and produce result 0)
//   - condition-code flag bit positions inside the CCR
//   - default operand width, CCR width and starvation limit
// No ports (package).
// -----------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    localparam int WIDTH_DEF        = 16;
    localparam int NFLAGS_DEF       = 5;
    localparam int STARVE_LIMIT_DEF = 4;

    // ALU function codes as seen on alu_func.
    typedef enum logic [3:0] {
        FUNC_NOP  = 4'h0,
        FUNC_SETC = 4'h1,
        FUNC_CLRC = 4'h2,
        FUNC_MOV1 = 4'h3,
        FUNC_MOV2 = 4'h4,
        FUNC_NOT  = 4'h5,
        FUNC_INC  = 4'h6,
        FUNC_DEC  = 4'h7,
        FUNC_ADD  = 4'h8,
        FUNC_SUB  = 4'h9,
        FUNC_AND  = 4'hA,
        FUNC_OR   = 4'hB,
        FUNC_SHL  = 4'hC,
        FUNC_SHR  = 4'hD
    } alu_func_e;

    // CCR bit positions; bits above FLAG_C are reserved and passed through.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // Requester identities as carried on rsp_id.
    localparam logic PORT_EXE = 1'b0;  // pipeline execute stage
    localparam logic PORT_AUX = 1'b1;  // stack / interrupt unit

    // Width of a counter that must hold the values 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
// Request/response bundle between the two ALU requesters and the arbiter.
//
// Handshake: a requester raises reqN_valid together with its operands,
// function and flag_we and holds them until it sees reqN_ready high in the
// same cycle; the operation transfers on the rising edge where both are high.
// reqN_ready is combinational from the valids and may drop at any time; a
// requester must never wait for ready before raising valid. rsp_valid is a
// one-cycle pulse exactly one cycle after the transfer, with rsp_id naming
// the port that owns it; rsp_result/rsp_flags hold their last value when
// rsp_valid is low.
//
// Modports:
//   master - requester side: drives req*, observes ready and rsp*
//   slave  - arbiter side:   drives ready and rsp*, observes req*
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int NFLAGS = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_op1;
    logic [WIDTH-1:0]  req0_op2;
    logic [3:0]        req0_func;
    logic              req0_flag_we;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_op1;
    logic [WIDTH-1:0]  req1_op2;
    logic [3:0]        req1_func;
    logic              req1_flag_we;

    logic              rsp_valid;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic [NFLAGS-1:0] rsp_flags;

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_func, req0_flag_we,
        output req1_valid, req1_op1, req1_op2, req1_func, req1_flag_we,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_func, req0_flag_we,
        input  req1_valid, req1_op1, req1_op2, req1_func, req1_flag_we,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter_grant_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_grant_ctrl
// Fixed-priority arbiter (port 0 preferred) with a starvation counter that
// forces a port-1 win after STARVE_LIMIT consecutive lost cycles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   hold_i            stall: no grant, counter frozen
//   req0_valid_i      port 0 request
//   req1_valid_i      port 1 request
//   gnt0_o, gnt1_o    one-hot grant (both low when idle), combinational
//   starve_cnt_o      current starvation count (debug visibility)
// -----------------------------------------------------------------------------
module alu_share_arbiter_grant_ctrl
    import alu_share_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = cnt_width(STARVE_LIMIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             req0_valid_i,
    input  logic             req1_valid_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic [CNT_W-1:0] starve_cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             can_grant;
    logic             force1;

    // Grants are also suppressed while reset is asserted so that nothing is
    // handed out to a requester the datapath is not going to answer.
    assign can_grant = rst_n && !hold_i;
    assign force1    = (starve_cnt_q == LIMIT_C);

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (can_grant) begin
            if (req0_valid_i && !(req1_valid_i && force1)) begin
                gnt0_o = 1'b1;
            end else if (req1_valid_i) begin
                gnt1_o = 1'b1;
            end
        end
    end

    // Count cycles where port 1 asks and loses; saturate so the forced win
    // persists until port 1 actually takes it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!hold_i) begin
            if (!req1_valid_i || gnt1_o) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != LIMIT_C) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_cnt_o = starve_cnt_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares the single execute-stage ALU between the pipeline execute stage
// (port 0) and the stack/interrupt unit (port 1). Grants at most one op per
// cycle, steers the winner's operands/function to the ALU, registers the
// ALU result/flags as a one-cycle response and owns the CCR fed back to the
// ALU.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   hold              hazard stall; no grant while high
//   ccr_load, ccr_in  restore the CCR (RTI); wins over any flag write
//   ccr               current CCR
//   alu_op1/op2/func  to ALU (0 / NOP when nothing is granted)
//   alu_flags_in      to ALU, always the registered CCR
//   alu_result        from ALU, combinational
//   alu_flags_out     from ALU, combinational
//   dbg_starve_cnt    starvation counter of the arbiter
//   bus               request/response interface (slave side)
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int NFLAGS       = NFLAGS_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 hold,
    input  logic                                 ccr_load,
    input  logic [NFLAGS-1:0]                    ccr_in,
    output logic [NFLAGS-1:0]                    ccr,
    output logic [WIDTH-1:0]                     alu_op1,
    output logic [WIDTH-1:0]                     alu_op2,
    output logic [3:0]                           alu_func,
    output logic [NFLAGS-1:0]                    alu_flags_in,
    input  logic [WIDTH-1:0]                     alu_result,
    input  logic [NFLAGS-1:0]                    alu_flags_out,
    output logic [cnt_width(STARVE_LIMIT)-1:0]   dbg_starve_cnt,
    alu_share_arbiter_if.slave                   bus
);

    logic              gnt0;
    logic              gnt1;
    logic              grant;
    logic              sel_flag_we;

    logic [NFLAGS-1:0] ccr_q;
    logic [NFLAGS-1:0] ccr_d;

    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic              rsp_id_q;
    logic              rsp_id_d;
    logic [WIDTH-1:0]  rsp_result_q;
    logic [WIDTH-1:0]  rsp_result_d;
    logic [NFLAGS-1:0] rsp_flags_q;
    logic [NFLAGS-1:0] rsp_flags_d;

    alu_share_arbiter_grant_ctrl #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold),
        .req0_valid_i (bus.req0_valid),
        .req1_valid_i (bus.req1_valid),
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1),
        .starve_cnt_o (dbg_starve_cnt)
    );

    assign grant          = gnt0 || gnt1;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Operand steering; an idle ALU sees zeros and NOP so its outputs stay
    // quiet when nobody owns it.
    always_comb begin
        alu_op1     = '0;
        alu_op2     = '0;
        alu_func    = FUNC_NOP;
        sel_flag_we = 1'b0;
        if (gnt0) begin
            alu_op1     = bus.req0_op1;
            alu_op2     = bus.req0_op2;
            alu_func    = bus.req0_func;
            sel_flag_we = bus.req0_flag_we;
        end else if (gnt1) begin
            alu_op1     = bus.req1_op1;
            alu_op2     = bus.req1_op2;
            alu_func    = bus.req1_func;
            sel_flag_we = bus.req1_flag_we;
        end
    end

    // The ALU always consumes the registered CCR, so an op granted this cycle
    // sees flags written by the op granted in the previous cycle.
    assign alu_flags_in = ccr_q;
    assign ccr          = ccr_q;

    // RTI restore outranks any flag write from a same-cycle grant.
    always_comb begin
        ccr_d = ccr_q;
        if (ccr_load) begin
            ccr_d = ccr_in;
        end else if (grant && sel_flag_we) begin
            ccr_d = alu_flags_out;
        end
    end

    // Response captures the raw ALU flags regardless of flag_we/ccr_load so
    // the requester always sees what its own op produced.
    always_comb begin
        rsp_valid_d  = grant;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (grant) begin
            rsp_id_d     = gnt1 ? PORT_AUX : PORT_EXE;
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            ccr_q        <= ccr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Bench for alu_share_arbiter: a behavioural ALU stub closes the ALU loop, a
// reference model tracks CCR / starvation / expected responses, one negedge
// process compares every cycle, and directed sequences pin literal values.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int WIDTH        = 16;
    localparam int NFLAGS       = 5;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;
    localparam int W            = 1 + NFLAGS + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              hold;
    logic              ccr_load;
    logic [NFLAGS-1:0] ccr_in;
    logic [NFLAGS-1:0] ccr;
    logic [WIDTH-1:0]  alu_op1;
    logic [WIDTH-1:0]  alu_op2;
    logic [3:0]        alu_func;
    logic [NFLAGS-1:0] alu_flags_in;
    logic [WIDTH-1:0]  alu_result;
    logic [NFLAGS-1:0] alu_flags_out;
    logic [CNT_W-1:0]  dbg_starve_cnt;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .NFLAGS(NFLAGS)) bus ();

    alu_share_arbiter #(
        .WIDTH        (WIDTH),
        .NFLAGS       (NFLAGS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .ccr_load       (ccr_load),
        .ccr_in         (ccr_in),
        .ccr            (ccr),
        .alu_op1        (alu_op1),
        .alu_op2        (alu_op2),
        .alu_func       (alu_func),
        .alu_flags_in   (alu_flags_in),
        .alu_result     (alu_result),
        .alu_flags_out  (alu_flags_out),
        .dbg_starve_cnt (dbg_starve_cnt),
        .bus            (bus)
    );

    // ---------------- ALU stub: returns {flags, result} ----------------
    function automatic logic [NFLAGS+WIDTH-1:0] alu_stub(input logic [3:0] f,
                                                          input logic [WIDTH-1:0] a,
                                                          input logic [WIDTH-1:0] b,
                                                          input logic [NFLAGS-1:0] fin);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             c;
        r = '0;
        c = fin[2];
        s = '0;
        case (f)
            4'h1: c = 1'b1;
            4'h2: c = 1'b0;
            4'h3: r = a;
            4'h4: r = b;
            4'h5: r = ~a;
            4'h6: r = a + 16'd1;
            4'h7: r = a - 16'd1;
            4'h8: begin s = {1'b0, a} + {1'b0, b}; r = s[WIDTH-1:0]; c = s[WIDTH]; end
            4'h9: begin r = a - b; c = (a < b); end
            4'hA: r = a & b;
            4'hB: r = a | b;
            4'hC: begin r = a << 1; c = a[WIDTH-1]; end
            4'hD: begin r = a >> 1; c = a[0]; end
            default: r = '0;
        endcase
        return {fin[4:3], c, r[WIDTH-1], (r == '0), r};
    endfunction

    always_comb {alu_flags_out, alu_result} = alu_stub(alu_func, alu_op1, alu_op2, alu_flags_in);

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [W-1:0]            exp_q[$];
    logic [W-1:0]            m_hold = '0;
    logic [NFLAGS-1:0]       m_ccr  = '0;
    int                      m_lost = 0;
    logic                    e_win0, e_win1, e_we, e_rv;
    logic [WIDTH-1:0]        e_a, e_b;
    logic [3:0]              e_f;
    logic [NFLAGS+WIDTH-1:0] e_res;

    // Model: port 0 is preferred unless port 1 has lost STARVE_LIMIT cycles
    // in a row; port 1 takes every grant port 0 does not take.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_ccr  = '0;
            m_lost = 0;
            m_hold = '0;
            exp_q.delete();
        end
        e_win0 = rst_n && !hold && bus.req0_valid && !(bus.req1_valid && m_lost >= STARVE_LIMIT);
        e_win1 = rst_n && !hold && bus.req1_valid && !e_win0;
        e_a = '0; e_b = '0; e_f = 4'h0; e_we = 1'b0;
        if (e_win0) begin
            e_a = bus.req0_op1; e_b = bus.req0_op2; e_f = bus.req0_func; e_we = bus.req0_flag_we;
        end else if (e_win1) begin
            e_a = bus.req1_op1; e_b = bus.req1_op2; e_f = bus.req1_func; e_we = bus.req1_flag_we;
        end
        e_res = alu_stub(e_f, e_a, e_b, m_ccr);

        check("ready0", 32'(bus.req0_ready), 32'(e_win0));
        check("ready1", 32'(bus.req1_ready), 32'(e_win1));
        check("alu_op1", 32'(alu_op1), 32'(e_a));
        check("alu_op2", 32'(alu_op2), 32'(e_b));
        check("alu_func", 32'(alu_func), 32'(e_f));
        check("alu_flags_in", 32'(alu_flags_in), 32'(m_ccr));
        check("ccr", 32'(ccr), 32'(m_ccr));
        check("starve_cnt", 32'(dbg_starve_cnt), 32'(m_lost));

        if (exp_q.size() > 0) begin
            e_rv   = 1'b1;
            m_hold = exp_q.pop_front();
        end else begin
            e_rv = 1'b0;
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        check("rsp_id", 32'(bus.rsp_id), 32'(m_hold[W-1]));
        check("rsp_flags", 32'(bus.rsp_flags), 32'(m_hold[W-2:WIDTH]));
        check("rsp_result", 32'(bus.rsp_result), 32'(m_hold[WIDTH-1:0]));

        if (rst_n) begin
            if (e_win0 || e_win1) exp_q.push_back({e_win1, e_res});
            if (ccr_load) m_ccr = ccr_in;
            else if ((e_win0 || e_win1) && e_we) m_ccr = e_res[NFLAGS+WIDTH-1:WIDTH];
            if (!hold) begin
                if (!bus.req1_valid || e_win1) m_lost = 0;
                else if (m_lost < STARVE_LIMIT) m_lost++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic we);
        bus.req0_valid = v; bus.req0_func = f; bus.req0_op1 = a; bus.req0_op2 = b;
        bus.req0_flag_we = we;
    endtask

    task automatic drive1(input logic v, input logic [3:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic we);
        bus.req1_valid = v; bus.req1_func = f; bus.req1_op1 = a; bus.req1_op2 = b;
        bus.req1_flag_we = we;
    endtask

    task automatic idle_all();
        drive0(1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
        drive1(1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
        hold = 1'b0; ccr_load = 1'b0; ccr_in = '0;
    endtask

    // ---------------- directed stimulus ----------------
    int pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        rst_n = 1'b0;
        idle_all();

        // Reset with random inputs: nothing granted, all registered outputs 0.
        for (int i = 0; i < 4; i++) begin
            tick();
            hold = 1'($urandom_range(0, 1)); ccr_load = 1'($urandom_range(0, 1));
            ccr_in = 5'($urandom_range(0, 31));
            drive0(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'b1);
            drive1(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'b1);
            @(negedge clk);
            check("rst_ready0", 32'(bus.req0_ready), 32'd0);
            check("rst_ready1", 32'(bus.req1_ready), 32'd0);
            check("rst_alu_func", 32'(alu_func), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_ccr", 32'(ccr), 32'd0);
        end
        tick(); rst_n = 1'b1; idle_all();

        // ADD 0xFFFF + 1 with flag write.
        tick(); drive0(1'b1, 4'h8, 16'hFFFF, 16'h0001, 1'b1);
        @(negedge clk);
        check("add_ready0", 32'(bus.req0_ready), 32'd1);
        tick(); idle_all();
        @(negedge clk);
        check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("add_rsp_result", 32'(bus.rsp_result), 32'h0000);
        check("add_rsp_flags", 32'(bus.rsp_flags), 32'h05);
        check("add_ccr", 32'(ccr), 32'h05);

        // Both ports valid continuously: port 1 forced every fifth cycle.
        tick();
        drive0(1'b1, 4'hA, 16'h00F0, 16'h0FF0, 1'b0);
        drive1(1'b1, 4'hB, 16'h0001, 16'h0002, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("fair_ready1", 32'(bus.req1_ready), 32'(pat[i]));
            if (i == 5) check("fair_cnt_clear", 32'(dbg_starve_cnt), 32'd0);
            tick();
        end
        idle_all(); ccr_load = 1'b1; ccr_in = 5'h00;

        // SETC with flag write, then port-1 ADD 5+3 without flag write.
        tick(); ccr_load = 1'b0; drive0(1'b1, 4'h1, 16'h0, 16'h0, 1'b1);
        @(negedge clk);
        check("setc_ccr_before", 32'(ccr), 32'h00);
        tick(); drive0(1'b0, 4'h0, 16'h0, 16'h0, 1'b0); drive1(1'b1, 4'h8, 16'd5, 16'd3, 1'b0);
        @(negedge clk);
        check("b2b_flags_in", 32'(alu_flags_in), 32'h05);
        check("b2b_ready1", 32'(bus.req1_ready), 32'd1);
        tick(); idle_all();
        @(negedge clk);
        check("b2b_rsp_id", 32'(bus.rsp_id), 32'd1);
        check("b2b_rsp_result", 32'(bus.rsp_result), 32'h0008);
        check("b2b_rsp_flags", 32'(bus.rsp_flags), 32'h00);
        check("b2b_ccr", 32'(ccr), 32'h05);

        // ccr_load collides with a flag-writing SUB 3-3.
        tick(); ccr_load = 1'b1; ccr_in = 5'h02; drive0(1'b1, 4'h9, 16'd3, 16'd3, 1'b1);
        @(negedge clk);
        check("load_ready0", 32'(bus.req0_ready), 32'd1);
        tick(); idle_all();
        @(negedge clk);
        check("load_ccr", 32'(ccr), 32'h02);
        check("load_rsp_flags", 32'(bus.rsp_flags), 32'h01);

        // Two contested cycles (count reaches 2), then hold for 3 cycles.
        tick();
        drive0(1'b1, 4'h6, 16'h0010, 16'h0, 1'b0);
        drive1(1'b1, 4'h7, 16'h0020, 16'h0, 1'b0);
        @(negedge clk);
        check("pre_hold_ready0_a", 32'(bus.req0_ready), 32'd1);
        tick();
        @(negedge clk);
        check("pre_hold_ready0_b", 32'(bus.req0_ready), 32'd1);
        tick(); hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_ready0", 32'(bus.req0_ready), 32'd0);
            check("hold_ready1", 32'(bus.req1_ready), 32'd0);
            check("hold_cnt", 32'(dbg_starve_cnt), 32'd2);
            if (k > 0) check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        hold = 1'b0;
        @(negedge clk);
        check("post_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_hold_ready0_a", 32'(bus.req0_ready), 32'd1);
        tick();
        @(negedge clk);
        check("post_hold_ready0_b", 32'(bus.req0_ready), 32'd1);
        tick();
        @(negedge clk);
        check("post_hold_ready1", 32'(bus.req1_ready), 32'd1);

        // Unassigned func codes pass through to the ALU.
        tick(); drive0(1'b0, 4'h0, 16'h0, 16'h0, 1'b0); drive1(1'b1, 4'hE, 16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        check("func_e_pass", 32'(alu_func), 32'hE);
        tick(); drive1(1'b0, 4'h0, 16'h0, 16'h0, 1'b0); drive0(1'b1, 4'hF, 16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        check("func_f_pass", 32'(alu_func), 32'hF);
        tick(); idle_all();
        @(negedge clk);
        check("func_f_result", 32'(bus.rsp_result), 32'h0000);

        // Reset pulse right after a granted flag-writing op.
        tick(); drive0(1'b1, 4'h8, 16'd1, 16'd1, 1'b1);
        @(negedge clk);
        check("mid_ready0", 32'(bus.req0_ready), 32'd1);
        tick(); rst_n = 1'b0; idle_all();
        @(negedge clk);
        check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_ccr", 32'(ccr), 32'h00);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("mid_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 40; i++) begin
            tick();
            hold     = ($urandom_range(0, 3) == 0);
            ccr_load = ($urandom_range(0, 5) == 0);
            ccr_in   = 5'($urandom_range(0, 31));
            drive0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                   16'($urandom), 1'($urandom_range(0, 1)));
            drive1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                   16'($urandom), 1'($urandom_range(0, 1)));
        end
        tick(); idle_all();
        repeat (3) @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter that shares the single execute-stage ALU between two requesters: the pipeline execute stage (port 0) and the auxiliary stack/interrupt unit (port 1). Grants at most one operation per cycle, drives the ALU operand/function/flag inputs, captures result and flags into a one-cycle response register, and owns the condition-code register (CCR) fed back to the ALU. Sits between the ID/EX pipeline register and the ALU.

## Interface
- WIDTH, 16, operand/result width
- NFLAGS, 5, CCR width (bit0 Z, bit1 N, bit2 C, bits 4:3 reserved, passed through)
- STARVE_LIMIT, 4, consecutive lost cycles before port 1 is forced to win
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  hazard-unit stall; no grant while high
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  grant this cycle (combinational)
- req0_op1/op2, req1_op1/op2  in  WIDTH  operands
- req0_func, req1_func  in  4  ALU function code
- req0_flag_we, req1_flag_we  in  1  commit ALU flags to CCR
- ccr_load  in  1  restore CCR (RTI path)
- ccr_in  in  NFLAGS  value for ccr_load
- ccr  out  NFLAGS  current CCR
- alu_op1, alu_op2  out  WIDTH  to ALU
- alu_func  out  4  to ALU
- alu_flags_in  out  NFLAGS  to ALU (always = ccr)
- alu_result  in  WIDTH  from ALU (combinational)
- alu_flags_out  in  NFLAGS  from ALU (combinational)
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  port that owns the response
- rsp_result  out  WIDTH  registered result
- rsp_flags  out  NFLAGS  registered ALU flags

## Operation
- Arbitration (combinational): hold=1 → no grant. Else only one valid → it wins. Both valid → port 0 wins unless starve_cnt == STARVE_LIMIT, then port 1 wins.
- Exactly one of req0_ready/req1_ready high when granting; both low otherwise. A request transfers when valid && ready.
- Granted port's op1/op2/func drive ALU; no grant → alu_op1=alu_op2=0, alu_func=4'b0000 (NOP).
- starve_cnt (width clog2(STARVE_LIMIT+1)): +1 per cycle with req1_valid && !req1_ready && !hold, saturating at STARVE_LIMIT; cleared on port-1 grant or req1_valid=0; frozen during hold.
- CCR update at clock edge, priority: ccr_load → ccr_in; else granted && flag_we → alu_flags_out; else unchanged.
- Response register loads on grant: rsp_valid=1, rsp_id, rsp_result=alu_result, rsp_flags=alu_flags_out (independent of flag_we and ccr_load). No grant → rsp_valid=0, data held.
- Func codes 0xE/0xF passed through unchanged; ALU yields result 0.

## Timing
- Reset values: ccr=0, starve_cnt=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0; ALU-side outputs follow idle rule (0/NOP).
- Grant: same cycle as valid (combinational ready). Response: exactly 1 cycle after grant.
- Back-to-back: op granted in cycle N with flag_we sees CCR updated by op granted in N-1 (alu_flags_in = registered ccr). Throughput 1 op/cycle.
- ccr_load and flag-writing grant same cycle → CCR = ccr_in; response still carries ALU flags.
- hold rising with requests pending → no response next cycle; requests retried after hold drops, arbitration state preserved.
- Reset asserted mid-operation: in-flight response discarded (rsp_valid=0), no CCR write.

## Structure
- Shared package alu_pkg: ALU func codes (NOP 0, SETC 1, CLRC 2, MOV1 3, MOV2 4, NOT 5, INC 6, DEC 7, ADD 8, SUB 9, AND A, OR B, SHL C, SHR D), flag indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, WIDTH/NFLAGS defaults.
- One sub-module: alu_grant_ctrl (priority + starvation counter, outputs one-hot grant). Datapath muxing, CCR and response register in top.

## Test plan
- Reset: drive rst_n=0 with random inputs → all registered outputs 0, alu_func=0, ready low until rst_n=1.
- Port 0 ADD 0xFFFF+0x0001, flag_we=1 → ready0 same cycle; next cycle rsp_valid=1, rsp_id=0, result 0x0000, rsp_flags Z=1 C=1 N=0, ccr=0x05.
- Both ports valid continuously, STARVE_LIMIT=4 → grants 0,0,0,0,1,0,0,0,0,1…; starve_cnt clears after each port-1 grant.
- Back-to-back SETC (flag_we) then port-1 ADD 5+3 flag_we=0 → alu_flags_in shows C=1 on second op; ccr unchanged after ADD, rsp_flags Z=0 N=0 C=0.
- ccr_load=1, ccr_in=0x02 same cycle as granted SUB 3-3 flag_we=1 → ccr=0x02; rsp_flags Z=1.
- hold=1 for 3 cycles with both valid → no ready, rsp_valid=0, starve_cnt frozen; rst_n pulsed during granted op → no response, ccr=0.
